// File: rtl/request_capture_unit.sv
// rtl/request_capture_unit.sv - request capture: sync, edge detect, sticky pending, service offer, drop count
module request_capture_unit #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [2:0]       req_i,
    input  logic [2:0]       enable_i,
    output logic [2:0]       pend_o,
    input  logic [1:0]       enc_i,
    output logic             srv_valid_o,
    output logic [1:0]       srv_id_o,
    input  logic             srv_ready_i,
    output logic [CNT_W-1:0] drop_cnt_o,
    input  logic             clr_drop_i
);

    typedef enum logic {IDLE, OFFER} state_t;

    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    state_t           state_q, state_d;
    logic [2:0]       sync_q [SYNC_STAGES];
    logic [2:0]       prev_q;
    logic [2:0]       pend_q;
    logic [1:0]       srv_id_q;
    logic [CNT_W-1:0] cnt_q;

    logic [2:0]       sync_out;
    logic [2:0]       evt;
    logic [2:0]       clr_vec;
    logic [2:0]       drops;
    logic [1:0]       drop_n;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W:0]   cnt_base;
    logic [CNT_W-1:0] cnt_d;
    logic             handshake;
    logic             load;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= req_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_out;
        end
    end

    assign sync_out  = sync_q[SYNC_STAGES-1];
    assign evt       = sync_out & ~prev_q;
    assign handshake = (state_q == OFFER) && srv_ready_i;
    assign load      = (state_q == IDLE) && (enc_i != 2'b00);

    always_comb begin
        clr_vec = 3'b000;
        if (handshake) begin
            case (srv_id_q)
                2'd1:    clr_vec = 3'b001;
                2'd2:    clr_vec = 3'b010;
                2'd3:    clr_vec = 3'b100;
                default: clr_vec = 3'b000;
            endcase
        end
    end

    // An event on a bit that stays pending (not being cleared this cycle) is lost
    assign drops  = evt & pend_q & ~clr_vec;
    assign drop_n = {1'b0, drops[0]} + {1'b0, drops[1]} + {1'b0, drops[2]};

    always_comb begin
        cnt_base = clr_drop_i ? '0 : {1'b0, cnt_q};
        cnt_sum  = cnt_base + (CNT_W+1)'(drop_n);
        cnt_d    = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= (pend_q & ~clr_vec) | evt;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            srv_id_q <= 2'b00;
        end else begin
            state_q <= state_d;
            if (load) srv_id_q <= enc_i;
            else if (handshake) srv_id_q <= 2'b00;
        end
    end

    // Offer is held until accepted; the return to IDLE forces a fresh encoder sample
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = OFFER;
            OFFER:   if (srv_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign pend_o      = pend_q & enable_i;
    assign srv_valid_o = (state_q == OFFER);
    assign srv_id_o    = srv_id_q;
    assign drop_cnt_o  = cnt_q;

endmodule
